alu_retry_controller: RTL and testbench
=======================================

# alu_retry_controller

Sequencing stage directly in front of the checked ALU: accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands, samples the result together with the adder/SRA/SLL checker flags, and re-executes the operation when the checker for the unit used reports an error. It returns the result downstream with a per-operation fault flag. It also maintains sticky fault status and a saturating error counter for the processor's status logic.

## Interface
- `MAX_RETRY`, default 2: re-executions allowed after the first failing attempt (0..15).
- `CNT_W`, default 16: width of `err_count`.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  controller can accept an operation.
- `in_opcode`  in  5  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra.
- `in_operandA`, `in_operandB`  in  32 each  operands.
- `in_shiftamt`  in  5  shift amount.
- `alu_opcode`  out  5  registered, to ALU `ctrl_ALUopcode`.
- `alu_operandA`, `alu_operandB`  out  32 each  registered, to ALU.
- `alu_shiftamt`  out  5  registered, to ALU.
- `alu_result`  in  32  ALU `data_result`.
- `adder_has_error`, `sra_has_error`, `sll_has_error`  in  1 each  checker flags.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  32  final result.
- `out_fault`  out  1  final attempt still failed its checker.
- `clear_status`  in  1  clear sticky status and counter.
- `fault_sticky`  out  1  an operation has ended with `out_fault` since the last clear.
- `fault_code`  out  3  sticky per-unit error seen (bit0 adder, bit1 sra, bit2 sll).
- `err_count`  out  `CNT_W`  failing attempts counted, saturating.

## Operation
- Relevant flag per opcode:
  - 0/1: `adder_has_error`.
  - 4: `sll_has_error`.
  - 5: `sra_has_error`.
  - All other opcodes: none. These always pass, and the other checker flags are ignored.
- FSM states: IDLE, EXEC, CHECK, DONE.
  - **IDLE:** `in_ready`=1. On `in_valid`, capture opcode, operands and shiftamt into the `alu_*` registers, clear `retry_cnt`, go to EXEC.
  - **EXEC:** ALU inputs are stable. At the end of the cycle, register `alu_result` and the relevant flag (`err_q`). Go to CHECK.
  - **CHECK, `err_q`=0:** go to DONE with `out_fault`=0.
  - **CHECK, `err_q`=1 and `retry_cnt` < `MAX_RETRY`:** increment `retry_cnt` and `err_count`, set the `fault_code` bit, go to EXEC. Operands are not reloaded.
  - **CHECK, `err_q`=1 and `retry_cnt` = `MAX_RETRY`:** increment `err_count`, set the `fault_code` bit, set `fault_sticky`, go to DONE with `out_fault`=1.
  - **DONE:** `out_valid`=1. `out_result`/`out_fault` are held stable until `out_valid && out_ready`, then go to IDLE.
- `err_count` saturates at 2^`CNT_W`−1; it never wraps.
- `clear_status` acts in any state: it zeroes `err_count`, `fault_code` and `fault_sticky`. An increment or set in the same cycle is applied after the clear, so the counter reads 1 and the bits are set.
- `alu_*` registers change only on acceptance in IDLE.

## Timing
- Reset values:
  - `in_ready`=1 (state IDLE).
  - `out_valid`=0, `out_fault`=0, `out_result`=0.
  - `alu_*`=0.
  - `fault_sticky`=0, `fault_code`=0, `err_count`=0, `retry_cnt`=0.
- `in_ready` and `out_valid` are decoded from the registered state and have no combinational path from `in_valid`/`out_ready`.
- No-error latency: accepted in cycle T, EXEC in T+1, CHECK in T+2, `out_valid` high in T+3.
- Each retry adds 2 cycles. Worst case `out_valid` arrives at T+3+2·`MAX_RETRY`.
- Throughput: at most one operation per 4 cycles. `in_ready` is 0 outside IDLE.
- `out_ready` held high: DONE lasts one cycle and IDLE follows. Back-to-back acceptance requires a cycle in IDLE.
- `reset` mid-operation: the in-flight operation is dropped with no `out_valid`. All status clears and the state returns to IDLE on the next edge.

## Configuration
- `ALU_FAULT_RETRY_EN` defined: retry behaviour as above.
- `ALU_FAULT_RETRY_EN` undefined: `MAX_RETRY` is treated as 0 and `retry_cnt` is not built. The first failing attempt goes straight to DONE with `out_fault`=1, increments `err_count` by 1 and sets `fault_sticky`. Latency is always T+3.

## Test plan
- Add, A=5, B=7, no flags -> `out_result`=12, `out_fault`=0, `out_valid` at T+3, `err_count`=0.
- SRA, A=0x80000000, shamt=4, `sra_has_error` high on the first attempt only -> one retry, `out_result`=0xF8000000 at T+5, `out_fault`=0, `err_count`=1, `fault_code`=3'b010, `fault_sticky`=0.
- Sub, `adder_has_error` stuck high, `MAX_RETRY`=2 -> `out_valid` at T+7, `out_fault`=1, `err_count`=3, `fault_sticky`=1. With the macro undefined: T+3, `err_count`=1.
- AND with `adder_has_error`/`sll_has_error` forced high -> no retry, `out_fault`=0, `fault_code`=0.
- `out_ready` low for 5 cycles in DONE -> result and fault held, `in_ready`=0. `clear_status` pulsed in the same cycle as a CHECK error -> `err_count`=1.
- `reset` asserted during EXEC of a retrying op -> no `out_valid`, `in_ready`=1 and all status 0 the next cycle. `CNT_W`=2 with 5 failing attempts -> `err_count`=3.

Source files
------------

// File: rtl/alu_retry_controller.sv
// Sequencer in front of the checked ALU: registers operands, samples result and checker flag,
// and re-executes on checker error. Retries are built only with `ALU_FAULT_RETRY_EN defined.
module alu_retry_controller #(
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [31:0]      in_operandA,
  input  logic [31:0]      in_operandB,
  input  logic [4:0]       in_shiftamt,
  output logic [4:0]       alu_opcode,
  output logic [31:0]      alu_operandA,
  output logic [31:0]      alu_operandB,
  output logic [4:0]       alu_shiftamt,
  input  logic [31:0]      alu_result,
  input  logic             adder_has_error,
  input  logic             sra_has_error,
  input  logic             sll_has_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_fault,
  input  logic             clear_status,
  output logic             fault_sticky,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [4:0]       r_alu_opcode;
  logic [31:0]      r_alu_a;
  logic [31:0]      r_alu_b;
  logic [4:0]       r_alu_shamt;
  logic [31:0]      r_result;
  logic             r_err_q;
  logic             r_out_fault;
  logic             r_fault_sticky;
  logic [2:0]       r_fault_code;
  logic [CNT_W-1:0] r_err_count;

  logic [2:0]       w_unit;
  logic             w_flag;
  logic             w_can_retry;
  logic             w_accept;
  logic             w_retry;
  logic             w_final_fail;
  logic             w_err_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_code_nxt;
  logic             w_sticky_nxt;

  // One-hot checked unit for the held opcode: bit0 adder, bit1 sra, bit2 sll.
  always_comb begin
    w_unit = '0;
    case (r_alu_opcode)
      5'd0, 5'd1: w_unit = 3'b001;
      5'd5:       w_unit = 3'b010;
      5'd4:       w_unit = 3'b100;
      default:    w_unit = '0;
    endcase
  end

  assign w_flag = |(w_unit & {sll_has_error, sra_has_error, adder_has_error});

`ifdef ALU_FAULT_RETRY_EN
  localparam logic [3:0] LP_MAX_RETRY = 4'(MAX_RETRY);

  logic [3:0] r_retry_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_retry_cnt <= '0;
    end else if (w_accept) begin
      r_retry_cnt <= '0;
    end else if (w_retry) begin
      r_retry_cnt <= r_retry_cnt + 4'd1;
    end
  end

  assign w_can_retry = (r_retry_cnt < LP_MAX_RETRY);
`else
  // Without retry support every failing attempt is final.
  assign w_can_retry = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_retry      = 1'b0;
    w_final_fail = 1'b0;
    w_err_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (!r_err_q) begin
          w_state_nxt = S_DONE;
        end else if (w_can_retry) begin
          w_retry     = 1'b1;
          w_err_inc   = 1'b1;
          w_state_nxt = S_EXEC;
        end else begin
          w_final_fail = 1'b1;
          w_err_inc    = 1'b1;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_shamt  <= '0;
      r_result     <= '0;
      r_err_q      <= 1'b0;
      r_out_fault  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_opcode <= in_opcode;
        r_alu_a      <= in_operandA;
        r_alu_b      <= in_operandB;
        r_alu_shamt  <= in_shiftamt;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_result;
        r_err_q  <= w_flag;
      end
      if (r_state == S_CHECK) begin
        r_out_fault <= w_final_fail;
      end
    end
  end

  // Clear is applied first so a same-cycle increment or set survives it.
  always_comb begin
    w_cnt_nxt    = clear_status ? '0 : r_err_count;
    w_code_nxt   = clear_status ? '0 : r_fault_code;
    w_sticky_nxt = clear_status ? 1'b0 : r_fault_sticky;
    if (w_err_inc) begin
      if (w_cnt_nxt != '1) w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
      w_code_nxt = w_code_nxt | w_unit;
    end
    if (w_final_fail) w_sticky_nxt = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_count    <= '0;
      r_fault_code   <= '0;
      r_fault_sticky <= 1'b0;
    end else begin
      r_err_count    <= w_cnt_nxt;
      r_fault_code   <= w_code_nxt;
      r_fault_sticky <= w_sticky_nxt;
    end
  end

  assign alu_opcode   = r_alu_opcode;
  assign alu_operandA = r_alu_a;
  assign alu_operandB = r_alu_b;
  assign alu_shiftamt = r_alu_shamt;
  assign out_result   = r_result;
  assign out_fault    = r_out_fault;
  assign fault_sticky = r_fault_sticky;
  assign fault_code   = r_fault_code;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_alu_retry_controller.sv
// Self-checking bench for alu_retry_controller: the bench plays the ALU and checkers and
// predicts latency, result and status from attempt-level rules (honours ALU_FAULT_RETRY_EN).
module tb_alu_retry_controller;

  localparam int unsigned MAXR = 2;
`ifdef ALU_FAULT_RETRY_EN
  localparam int unsigned R_EFF = MAXR;
`else
  localparam int unsigned R_EFF = 0;
`endif
  localparam int unsigned RST_AT = (R_EFF > 0) ? 3 : 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [31:0] in_operandA;
  logic [31:0] in_operandB;
  logic [4:0]  in_shiftamt;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_shiftamt;
  logic [31:0] alu_result;
  logic        adder_has_error;
  logic        sra_has_error;
  logic        sll_has_error;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_fault;
  logic        clear_status;
  logic        fault_sticky;
  logic [2:0]  fault_code;
  logic [15:0] err_count;

  logic        in_ready2;
  logic [4:0]  alu_opcode2;
  logic [31:0] alu_operandA2;
  logic [31:0] alu_operandB2;
  logic [4:0]  alu_shiftamt2;
  logic        out_valid2;
  logic [31:0] out_result2;
  logic        out_fault2;
  logic        fault_sticky2;
  logic [2:0]  fault_code2;
  logic [1:0]  err_count2;

  int checks = 0;
  int errors = 0;

  // Reference status: total failing attempts (unbounded), unit bits, sticky fault.
  int unsigned m_cnt = 0;
  logic [2:0]  m_code = '0;
  logic        m_sticky = 1'b0;

  always #5 clock = ~clock;

  alu_retry_controller #(.MAX_RETRY(MAXR), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_operandA(in_operandA), .in_operandB(in_operandB),
    .in_shiftamt(in_shiftamt), .alu_opcode(alu_opcode), .alu_operandA(alu_operandA),
    .alu_operandB(alu_operandB), .alu_shiftamt(alu_shiftamt), .alu_result(alu_result),
    .adder_has_error(adder_has_error), .sra_has_error(sra_has_error),
    .sll_has_error(sll_has_error), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_fault(out_fault), .clear_status(clear_status),
    .fault_sticky(fault_sticky), .fault_code(fault_code), .err_count(err_count)
  );

  alu_retry_controller #(.MAX_RETRY(MAXR), .CNT_W(2)) u_dut_w2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_operandA(in_operandA), .in_operandB(in_operandB),
    .in_shiftamt(in_shiftamt), .alu_opcode(alu_opcode2), .alu_operandA(alu_operandA2),
    .alu_operandB(alu_operandB2), .alu_shiftamt(alu_shiftamt2), .alu_result(alu_result),
    .adder_has_error(adder_has_error), .sra_has_error(sra_has_error),
    .sll_has_error(sll_has_error), .out_valid(out_valid2), .out_ready(out_ready),
    .out_result(out_result2), .out_fault(out_fault2), .clear_status(clear_status),
    .fault_sticky(fault_sticky2), .fault_code(fault_code2), .err_count(err_count2)
  );

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << sh;
      5'd5:    return $signed(a) >>> sh;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_opcode, alu_operandA, alu_operandB, alu_shiftamt);

  function automatic logic [2:0] unit_of(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd1) return 3'b001;
    if (op == 5'd5) return 3'b010;
    if (op == 5'd4) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [15:0] sat16(input int unsigned v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [1:0] sat2(input int unsigned v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  task automatic set_flags(input logic [2:0] u, input bit err, input bit force_all);
    adder_has_error = u[0] ? err : (force_all ? 1'b1 : 1'($urandom));
    sra_has_error   = u[1] ? err : (force_all ? 1'b1 : 1'($urandom));
    sll_has_error   = u[2] ? err : (force_all ? 1'b1 : 1'($urandom));
  endtask

  // One transaction. k = number of leading attempts whose checker reports an error.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input int unsigned k, input int unsigned hold,
                       input bit clr, input bit force_all, input string tag);
    logic [2:0]  u;
    logic [31:0] exp_res;
    int unsigned retries;
    int unsigned n_fail;
    int unsigned lat;
    bit          fault;
    bit          got;
    int          n_seen;
    u = unit_of(op);
    exp_res = alu_fn(op, a, b, sh);
    if (u == 3'b000) begin
      retries = 0; n_fail = 0; fault = 1'b0;
    end else begin
      retries = (k < R_EFF) ? k : R_EFF;
      fault   = (k > R_EFF);
      n_fail  = fault ? R_EFF + 1 : k;
    end
    lat = 3 + 2 * retries;

    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s accept_ready: in_ready=%b out_valid=%b expected 1/0", tag, in_ready, out_valid);
    end
    in_valid = 1'b1; in_opcode = op; in_operandA = a; in_operandB = b; in_shiftamt = sh;
    out_ready = (hold == 0);
    set_flags(u, 1'b0, force_all);
    @(posedge clock);

    got = 1'b0; n_seen = 0;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(negedge clock);
      in_valid = 1'b0;
      set_flags(u, (n <= 2 * k), force_all);
      clear_status = clr && (n == 2);
      if (out_valid === 1'b1) begin
        got = 1'b1; n_seen = n;
      end else begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_ready: in_ready=%b expected 0 at cycle +%0d", tag, in_ready, n);
        end
      end
    end
    clear_status = 1'b0;

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no out_valid within 60 cycles, expected at +%0d", tag, lat);
      out_ready = 1'b1;
    end else begin
      if (n_seen != int'(lat)) begin
        errors++;
        $display("FAIL %s latency: got +%0d expected +%0d", tag, n_seen, lat);
      end
      if (clr) begin
        m_cnt = 0; m_code = '0; m_sticky = 1'b0;
      end
      m_cnt += n_fail;
      if (n_fail > 0) m_code |= u;
      if (fault) m_sticky = 1'b1;

      checks++;
      if (out_result !== exp_res) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", tag, out_result, exp_res);
      end
      checks++;
      if (out_fault !== fault) begin
        errors++;
        $display("FAIL %s out_fault: got %b expected %b", tag, out_fault, fault);
      end
      checks++;
      if (err_count !== sat16(m_cnt)) begin
        errors++;
        $display("FAIL %s err_count: got %0d expected %0d", tag, err_count, sat16(m_cnt));
      end
      checks++;
      if (err_count2 !== sat2(m_cnt)) begin
        errors++;
        $display("FAIL %s err_count_w2: got %0d expected %0d", tag, err_count2, sat2(m_cnt));
      end
      checks++;
      if (fault_code !== m_code) begin
        errors++;
        $display("FAIL %s fault_code: got %b expected %b", tag, fault_code, m_code);
      end
      checks++;
      if (fault_sticky !== m_sticky) begin
        errors++;
        $display("FAIL %s fault_sticky: got %b expected %b", tag, fault_sticky, m_sticky);
      end
      for (int h = 1; h <= int'(hold); h++) begin
        @(negedge clock);
        set_flags(u, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== exp_res || out_fault !== fault) begin
          errors++;
          $display("FAIL %s hold: valid=%b ready=%b result=%h fault=%b expected 1/0/%h/%b", tag,
                   out_valid, in_ready, out_result, out_fault, exp_res, fault);
        end
      end
      out_ready = 1'b1;
    end
    @(posedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_fault !== 1'b0 || out_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_handshake: ready=%b valid=%b fault=%b result=%h expected 1/0/0/0", in_ready, out_valid, out_fault, out_result);
    end
    checks++;
    if (alu_opcode !== 5'd0 || alu_operandA !== 32'd0 || alu_operandB !== 32'd0 || alu_shiftamt !== 5'd0) begin
      errors++;
      $display("FAIL reset_alu_regs: op=%h a=%h b=%h sh=%h expected all 0", alu_opcode, alu_operandA, alu_operandB, alu_shiftamt);
    end
    checks++;
    if (err_count !== 16'd0 || err_count2 !== 2'd0 || fault_code !== 3'd0 || fault_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: cnt=%0d cnt2=%0d code=%b sticky=%b expected 0", err_count, err_count2, fault_code, fault_sticky);
    end
    m_cnt = 0; m_code = '0; m_sticky = 1'b0;
  endtask

  task automatic test_clear_idle();
    @(negedge clock);
    clear_status = 1'b1;
    @(negedge clock);
    clear_status = 1'b0;
    m_cnt = 0; m_code = '0; m_sticky = 1'b0;
    checks++;
    if (err_count !== 16'd0 || fault_code !== 3'd0 || fault_sticky !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_idle: cnt=%0d code=%b sticky=%b ready=%b expected 0/0/0/1", err_count, fault_code, fault_sticky, in_ready);
    end
  endtask

  task automatic test_add();
    do_op(5'd0, 32'd5, 32'd7, 5'd0, 0, 0, 1'b0, 1'b0, "add");
  endtask

  task automatic test_sra_retry();
    do_op(5'd5, 32'h8000_0000, 32'h1234_5678, 5'd4, 1, 0, 1'b0, 1'b0, "sra_retry");
  endtask

  task automatic test_stuck_sub();
    do_op(5'd1, $urandom, $urandom, 5'd0, 99, 0, 1'b0, 1'b0, "sub_stuck");
  endtask

  task automatic test_and_forced();
    test_clear_idle();
    do_op(5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3, 99, 0, 1'b0, 1'b1, "and_forced");
  endtask

  task automatic test_hold_and_clear();
    do_op(5'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1, 5, 1'b1, 1'b0, "hold_clear");
  endtask

  task automatic test_back_to_back();
    do_op(5'd3, 32'h00FF_0000, 32'h0000_00FF, 5'd0, 0, 0, 1'b0, 1'b0, "b2b_or");
    do_op(5'd4, 32'h0000_0001, 32'd0, 5'd31, 0, 0, 1'b0, 1'b0, "b2b_sll");
    do_op(5'd1, 32'd3, 32'd10, 5'd0, 0, 0, 1'b0, 1'b0, "b2b_sub");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_op(5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 2), ($urandom_range(0, 7) == 0), 1'b0, "random");
    end
  endtask

  task automatic test_cnt_sat();
    test_clear_idle();
    for (int i = 0; i < 8 && m_cnt < 5; i++) begin
      do_op(5'd1, $urandom, $urandom, 5'd0, 99, 0, 1'b0, 1'b0, "cnt_sat");
    end
  endtask

  task automatic test_reset_midop();
    bit early;
    early = 1'b0;
    @(negedge clock);
    in_valid = 1'b1; in_opcode = 5'd1; in_operandA = 32'd9; in_operandB = 32'd4; in_shiftamt = 5'd0;
    out_ready = 1'b1;
    set_flags(3'b001, 1'b1, 1'b0);
    @(posedge clock);
    for (int n = 1; n <= int'(RST_AT); n++) begin
      @(negedge clock);
      in_valid = 1'b0;
      set_flags(3'b001, 1'b1, 1'b0);
      if (out_valid !== 1'b0) early = 1'b1;
      if (n == int'(RST_AT)) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    m_cnt = 0; m_code = '0; m_sticky = 1'b0;
    checks++;
    if (early || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_state: early_valid=%b ready=%b valid=%b expected 0/1/0", early, in_ready, out_valid);
    end
    checks++;
    if (err_count !== 16'd0 || err_count2 !== 2'd0 || fault_code !== 3'd0 || fault_sticky !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_status: cnt=%0d code=%b sticky=%b expected 0", err_count, fault_code, fault_sticky);
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midop_reset_quiet: valid=%b ready=%b expected 0/1", out_valid, in_ready);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_operandA = '0; in_operandB = '0;
    in_shiftamt = '0; adder_has_error = 1'b0; sra_has_error = 1'b0; sll_has_error = 1'b0;
    out_ready = 1'b0; clear_status = 1'b0;
    test_reset();
    test_add();
    test_sra_retry();
    test_stuck_sub();
    test_and_forced();
    test_hold_and_clear();
    test_back_to_back();
    test_random();
    test_cnt_sat();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
